alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_pkg.sv | 32 +++
 rtl/btn_edge_detect.sv | 60 ++++++
 rtl/alu_operand_loader.sv | 115 +++++++++++
 tb/tb_alu_operand_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: default widths, FSM encodings, opcode set.
// Pure declarations; no logic, latency or backpressure of its own.
package alu_pkg;

  localparam int DEF_N_BITS          = 6;
  localparam int DEF_N_OPS           = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_A    = 2'b00;
  localparam state_t S_B    = 2'b01;
  localparam state_t S_OP   = 2'b10;
  localparam state_t S_EXEC = 2'b11;

  localparam logic [DEF_N_OPS-1:0] OP_ADD = 6'b100000;
  localparam logic [DEF_N_OPS-1:0] OP_SUB = 6'b100010;
  localparam logic [DEF_N_OPS-1:0] OP_AND = 6'b100100;
  localparam logic [DEF_N_OPS-1:0] OP_OR  = 6'b100101;
  localparam logic [DEF_N_OPS-1:0] OP_XOR = 6'b100110;
  localparam logic [DEF_N_OPS-1:0] OP_SRA = 6'b000011;
  localparam logic [DEF_N_OPS-1:0] OP_SRL = 6'b000010;
  localparam logic [DEF_N_OPS-1:0] OP_NOR = 6'b100111;

  function automatic logic is_valid_op(input logic [DEF_N_OPS-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_valid_op = 1'b1;
      default:                                                       is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Button conditioner: 2-flop sync, optional stable-high filter (LOADER_DEBOUNCE_EN), rising-edge pulse.
// Latency: pulse visible 2 edges after first high sample (no filter); no backpressure, events are one-shot.
module btn_edge_detect #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic [1:0] primed;
  logic       armed;
  logic       level;
  logic       level_d;

  // armed only after a genuine low sample, so a button held through reset stays silent
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      primed  <= 2'b00;
      armed   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      primed  <= {primed[0], 1'b1};
      level_d <= level;
      if (primed[1] && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt <= '0;
    end else if (!sync2) begin
      stable_cnt <= '0;
    end else if (stable_cnt != CW'(DEBOUNCE_CYCLES)) begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  assign level = (stable_cnt == CW'(DEBOUNCE_CYCLES));
`else
  assign level = sync2;
`endif

  assign press = level & ~level_d & armed;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads ALU operands A, B and opcode from switches on button presses, then captures the ALU result.
// Optional LOADER_DEBOUNCE_EN filters buttons; presses that do not match the current state are dropped.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N_BITS          = DEF_N_BITS,
  parameter int N_OPS           = DEF_N_OPS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_switches,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  input  logic [N_BITS-1:0] i_result,
  output logic [N_BITS-1:0] o_data_a,
  output logic [N_BITS-1:0] o_data_b,
  output logic [N_OPS-1:0]  o_op,
  output logic              o_op_valid,
  output logic [N_BITS-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_op_err,
  output logic [1:0]        o_state
);

  logic press_a;
  logic press_b;
  logic press_op;

  btn_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clock (clock),
    .reset (reset),
    .btn   (i_btn_a),
    .press (press_a)
  );

  btn_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clock (clock),
    .reset (reset),
    .btn   (i_btn_b),
    .press (press_b)
  );

  btn_edge_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
    .clock (clock),
    .reset (reset),
    .btn   (i_btn_op),
    .press (press_op)
  );

  state_t               state;
  logic                 exec_cnt;
  logic [DEF_N_OPS-1:0] op_cand;

  assign op_cand = DEF_N_OPS'(i_switches[N_OPS-1:0]);
  assign o_state = state;

  // S_EXEC spans two edges so the registered ALU output reflects the new operands
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_A;
      exec_cnt       <= 1'b0;
      o_data_a       <= '0;
      o_data_b       <= '0;
      o_op           <= '0;
      o_op_valid     <= 1'b0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_op_err       <= 1'b0;
    end else begin
      o_op_valid <= 1'b0;
      case (state)
        S_A: begin
          if (press_a) begin
            o_data_a       <= i_switches;
            o_result_valid <= 1'b0;
            state          <= S_B;
          end
        end
        S_B: begin
          if (press_b) begin
            o_data_b <= i_switches;
            state    <= S_OP;
          end
        end
        S_OP: begin
          if (press_op) begin
            if (is_valid_op(op_cand)) begin
              o_op       <= i_switches[N_OPS-1:0];
              o_op_err   <= 1'b0;
              o_op_valid <= 1'b1;
              exec_cnt   <= 1'b0;
              state      <= S_EXEC;
            end else begin
              o_op_err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (exec_cnt) begin
            o_result       <= i_result;
            o_result_valid <= 1'b1;
            exec_cnt       <= 1'b0;
            state          <= S_A;
          end else begin
            exec_cnt <= 1'b1;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with a registered ALU model on i_result.
`timescale 1ns/1ps
module tb_alu_operand_loader;

  localparam int NB  = 6;
  localparam int NO  = 6;
  localparam int DEB = 16;
`ifdef LOADER_DEBOUNCE_EN
  localparam int HOLD = DEB + 6;
`else
  localparam int HOLD = 4;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] i_switches = '0;
  logic          i_btn_a = 1'b0;
  logic          i_btn_b = 1'b0;
  logic          i_btn_op = 1'b0;
  logic [NB-1:0] alu_q = '0;
  logic [NB-1:0] o_data_a, o_data_b, o_result;
  logic [NO-1:0] o_op;
  logic          o_op_valid, o_result_valid, o_op_err;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [NO-1:0] op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } op_exp_t;

  op_exp_t       op_q[$];
  logic [NB-1:0] res_q[$];

  alu_operand_loader #(.N_BITS(NB), .N_OPS(NO), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_switches     (i_switches),
    .i_btn_a        (i_btn_a),
    .i_btn_b        (i_btn_b),
    .i_btn_op       (i_btn_op),
    .i_result       (alu_q),
    .o_data_a       (o_data_a),
    .o_data_b       (o_data_b),
    .o_op           (o_op),
    .o_op_valid     (o_op_valid),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_op_err       (o_op_err),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  function automatic logic [NB-1:0] alu_f(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic [NO-1:0] op);
    case (op)
      6'b100000: alu_f = a + b;
      6'b100010: alu_f = a - b;
      6'b100100: alu_f = a & b;
      6'b100101: alu_f = a | b;
      6'b100110: alu_f = a ^ b;
      6'b000011: alu_f = $signed(b) >>> a[2:0];
      6'b000010: alu_f = b >> a[2:0];
      6'b100111: alu_f = ~(a | b);
      default:   alu_f = '0;
    endcase
  endfunction

  always @(posedge clock) alu_q <= alu_f(o_data_a, o_data_b, o_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [2:0] which, input logic [NB-1:0] sw);
    i_switches = sw;
    {i_btn_op, i_btn_b, i_btn_a} = which;
    tick(HOLD);
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    tick(4);
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int budget);
    int k;
    k = 0;
    while (o_state !== s && k < budget) begin
      tick(1);
      k++;
    end
    check(name, o_state, s);
  endtask

  // Monitor: pops expectations whenever the DUT issues an opcode or raises result valid.
  logic    ov_prev = 1'b0;
  logic    rv_prev = 1'b0;
  op_exp_t op_exp;
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (o_op_valid) begin
        check("op_valid_single_pulse", ov_prev, 0);
        if (op_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL op_issue: o_op_valid with op=0x%0h, expected no issue", o_op);
        end else begin
          op_exp = op_q.pop_front();
          check("op_issue", {o_op, o_data_a, o_data_b}, op_exp);
        end
      end
      if (o_result_valid && !rv_prev) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_capture: result 0x%0h, expected no capture", o_result);
        end else begin
          check("result_capture", o_result, res_q.pop_front());
        end
      end
      ov_prev = o_op_valid;
      rv_prev = o_result_valid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    tick(1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_outputs", {o_data_a, o_data_b, o_op, o_result, o_result_valid,
                            o_op_valid, o_op_err, o_state}, 0);
    tick(4);

    // A=5, B=3, ADD -> 8
`ifndef LOADER_DEBOUNCE_EN
    i_switches = 6'd5;
    i_btn_a = 1'b1;
    tick(2);
    check("latency_edge2_state", o_state, 2'b00);
    tick(1);
    check("latency_edge3_state", o_state, 2'b01);
    tick(1);
    i_btn_a = 1'b0;
    tick(4);
`else
    press(3'b001, 6'd5);
`endif
    check("load_a_5", o_data_a, 6'd5);
    press(3'b010, 6'd3);
    check("state_after_b", o_state, 2'b10);
    check("load_b_3", o_data_b, 6'd3);
    op_q.push_back({6'b100000, 6'd5, 6'd3});
    res_q.push_back(6'd8);
    press(3'b100, 6'b100000);
    wait_state("add_back_to_s_a", 2'b00, 20);
    check("add_result_valid", o_result_valid, 1);
    check("add_result", o_result, 6'd8);

    // A=3, B=5, SUB -> -2
    press(3'b001, 6'd3);
    check("btn_a_clears_valid", o_result_valid, 0);
    press(3'b010, 6'd5);
    op_q.push_back({6'b100010, 6'd3, 6'd5});
    res_q.push_back(6'b111110);
    press(3'b100, 6'b100010);
    wait_state("sub_back_to_s_a", 2'b00, 20);
    check("sub_result", o_result, 6'b111110);
    press(3'b001, 6'd7);
    check("next_a_clears_valid", o_result_valid, 0);
    check("result_held", o_result, 6'b111110);

    // invalid opcode then AND
    press(3'b010, 6'd2);
    press(3'b100, 6'b111111);
    check("bad_op_err", o_op_err, 1);
    check("bad_op_keeps_op", o_op, 6'b100010);
    check("bad_op_state", o_state, 2'b10);
    op_q.push_back({6'b100100, 6'd7, 6'd2});
    res_q.push_back(6'd2);
    press(3'b100, 6'b100100);
    wait_state("and_back_to_s_a", 2'b00, 20);
    check("good_op_clears_err", o_op_err, 0);
    check("and_result", o_result, 6'd2);

    // mismatched and simultaneous presses in S_A
    press(3'b010, 6'd9);
    check("b_in_s_a_ignored_state", o_state, 2'b00);
    check("b_in_s_a_ignored_data", o_data_b, 6'd2);
    press(3'b100, 6'b100000);
    check("op_in_s_a_ignored", o_state, 2'b00);
    press(3'b111, 6'd12);
    check("simultaneous_state", o_state, 2'b01);
    check("simultaneous_a", o_data_a, 6'd12);
    check("simultaneous_b_kept", o_data_b, 6'd2);

    // reset one cycle after issue; btn_a held through reset
    press(3'b010, 6'd1);
    op_q.push_back({6'b100000, 6'd12, 6'd1});
    i_switches = 6'b100000;
    i_btn_op = 1'b1;
    k = 0;
    while (!o_op_valid && k < 60) begin
      tick(1);
      k++;
    end
    check("op_valid_before_reset", o_op_valid, 1);
    reset = 1'b1;
    i_btn_op = 1'b0;
    i_btn_a = 1'b1;
    i_switches = 6'd21;
    tick(2);
    reset = 1'b0;
    check("abort_outputs", {o_data_a, o_data_b, o_op, o_result, o_result_valid,
                            o_op_valid, o_op_err, o_state}, 0);
    tick(8);
    check("held_btn_no_event_state", o_state, 2'b00);
    check("held_btn_no_event_a", o_data_a, 6'd0);
    check("abort_no_capture", o_result_valid, 0);
    i_btn_a = 1'b0;
    tick(4);

`ifdef LOADER_DEBOUNCE_EN
    i_switches = 6'd33;
    i_btn_a = 1'b1;
    tick(10);
    i_btn_a = 1'b0;
    tick(30);
    check("short_pulse_ignored", o_state, 2'b00);
    i_btn_a = 1'b1;
    tick(20);
    i_btn_a = 1'b0;
    tick(30);
    check("long_pulse_state", o_state, 2'b01);
    check("long_pulse_a", o_data_a, 6'd33);
`else
    press(3'b001, 6'd21);
    check("press_after_release_state", o_state, 2'b01);
    check("press_after_release_a", o_data_a, 6'd21);
`endif

    tick(4);
    check("op_queue_drained", op_q.size(), 0);
    check("res_queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
